matmul_seq_ctrl: RTL and testbench
==================================

MATMUL_SEQ_CTRL -- requirements
Module: matmul_seq_ctrl

Interface
REQ-001 Parameter: W, default 16, width of the dimension inputs and the index outputs.
REQ-002 Port: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1; reset is asynchronous and active-low.
REQ-004 Port: start, input, 1, request to begin one i/j/k loop nest; sampled only in IDLE.
REQ-005 Port: abort, input, 1, terminates a running nest without a done pulse.
REQ-006 Port: stall, input, 1, freezes sequencing while high.
REQ-007 Port: dim_m / dim_n / dim_k, input, W each, loop bounds for i / j / k; latched on an accepted start.
REQ-008 Port: idx_i / idx_j / idx_k, output, W each, current loop indices; registered.
REQ-009 Port: mac_en, output, 1, current indices are valid for one MAC beat.
REQ-010 Port: acc_clr, output, 1, clear the accumulator with this beat (k == 0).
REQ-011 Port: acc_wr, output, 1, write back the accumulator after this beat (k == K-1).
REQ-012 Port: busy, output, 1, high in RUN and DONE.
REQ-013 Port: done, output, 1, one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 and all dims nonzero: latch dims, clear indices, go to RUN on the next edge.
REQ-016 IDLE with start=1 and any dim == 0: go to DONE directly; no mac_en is ever issued.
REQ-017 start SHALL be ignored outside IDLE; latched dims SHALL NOT change until the next accepted start.
REQ-018 mac_en SHALL equal (state == RUN) & ~stall & ~abort; it is combinational from registered state and inputs.
REQ-019 acc_clr SHALL equal mac_en & (idx_k == 0).
REQ-020 acc_wr SHALL equal mac_en & (idx_k == K-1).
REQ-021 Index advance on each mac_en edge, k innermost:
- k increments.
- At k == K-1: k wraps to 0 and j increments.
- At j == N-1 (with k wrap): j wraps to 0 and i increments.
REQ-022 A mac_en beat at (M-1, N-1, K-1) SHALL move the FSM to DONE and reset all indices to 0.
REQ-023 stall=1 in RUN SHALL hold the indices and state unchanged, for any stall length.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 abort=1 in RUN SHALL return the FSM to IDLE on the next edge with indices zeroed and no done; abort has priority over stall.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 Timing with no stalls: first beat in the cycle after start is accepted; exactly M*N*K beats are issued; done is asserted the cycle after the final beat.
REQ-028 Index comparisons SHALL be full W-bit unsigned; dims up to 2^W-1 SHALL be supported with no overflow of the indices.

Reset
REQ-029 reset low SHALL immediately, without a clock edge, force the following:
- state to IDLE;
- idx_i, idx_j, idx_k and the latched dims to 0;
- busy, done, mac_en, acc_clr and acc_wr to 0.
REQ-030 Reset asserted mid-run SHALL discard the nest; after release the block waits in IDLE for a new start.

Verification
REQ-031 Basic nest: M=N=K=2, no stall.
- mac_en high 8 consecutive cycles.
- Indices in order (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0),(1,0,1),(1,1,0),(1,1,1).
- acc_clr on beats 1,3,5,7; acc_wr on beats 2,4,6,8.
- done on cycle 9, then busy=0.
REQ-032 Stall: M=N=K=2, stall=1 for 3 cycles while (0,1,0) is presented.
- Indices hold at (0,1,0) and mac_en=0 for those 3 cycles.
- 8 beats total; done on cycle 12.
REQ-033 Zero dimension: start with dim_k=0.
- No mac_en.
- busy and done high for one cycle, in the cycle after start, then IDLE.
REQ-034 Abort: M=N=K=4, abort at beat 10.
- busy=0 the next cycle, indices 0, no done pulse.
- A following start runs a full nest correctly.
REQ-035 Single beat: M=N=K=1.
- One beat at (0,0,0) with acc_clr=1 and acc_wr=1.
- done on the next cycle.
REQ-036 Reset mid-run: drive reset low between clock edges during a run.
- All outputs go to 0 before the next edge.
- start after release begins a fresh nest at (0,0,0).

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// i/j/k loop-nest sequencer for a MAC datapath.
// Issues one index triple per beat, k innermost, with accumulator clear/write strobes.
module matmul_seq_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic         stall,
  input  logic [W-1:0] dim_m,
  input  logic [W-1:0] dim_n,
  input  logic [W-1:0] dim_k,
  output logic [W-1:0] idx_i,
  output logic [W-1:0] idx_j,
  output logic [W-1:0] idx_k,
  output logic         mac_en,
  output logic         acc_clr,
  output logic         acc_wr,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] n_q, n_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] i_q, i_d;
  logic [W-1:0] j_q, j_d;
  logic [W-1:0] kk_q, kk_d;

  logic i_last, j_last, k_last;
  logic any_zero;

  assign i_last   = (i_q  == m_q - ONE);
  assign j_last   = (j_q  == n_q - ONE);
  assign k_last   = (kk_q == k_q - ONE);
  assign any_zero = (dim_m == '0) | (dim_n == '0) | (dim_k == '0);

  assign mac_en  = (state_q == S_RUN) & ~stall & ~abort;
  assign acc_clr = mac_en & (kk_q == '0);
  assign acc_wr  = mac_en & k_last;
  assign busy    = (state_q == S_RUN) | (state_q == S_DONE);
  assign done    = (state_q == S_DONE);
  assign idx_i   = i_q;
  assign idx_j   = j_q;
  assign idx_k   = kk_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    kk_d    = kk_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = dim_m;
          n_d     = dim_n;
          k_d     = dim_k;
          i_d     = '0;
          j_d     = '0;
          kk_d    = '0;
          state_d = any_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          i_d     = '0;
          j_d     = '0;
          kk_d    = '0;
          state_d = S_IDLE;
        end else if (mac_en) begin
          if (!k_last) begin
            kk_d = kk_q + ONE;
          end else begin
            kk_d = '0;
            if (!j_last) begin
              j_d = j_q + ONE;
            end else begin
              j_d = '0;
              if (!i_last) begin
                i_d = i_q + ONE;
              end else begin
                i_d     = '0;
                state_d = S_DONE;
              end
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      kk_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kk_q    <= kk_d;
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl.
// Flags are packed as {mac_en, acc_clr, acc_wr, busy, done}.
module tb_matmul_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        stall;
  logic [15:0] dim_m, dim_n, dim_k;
  logic [15:0] idx_i, idx_j, idx_k;
  logic        mac_en, acc_clr, acc_wr, busy, done;

  int vectors;
  int miscompares;

  matmul_seq_ctrl #(.W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .stall  (stall),
    .dim_m  (dim_m),
    .dim_n  (dim_n),
    .dim_k  (dim_k),
    .idx_i  (idx_i),
    .idx_j  (idx_j),
    .idx_k  (idx_k),
    .mac_en (mac_en),
    .acc_clr(acc_clr),
    .acc_wr (acc_wr),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_flags(input string tag, input logic [4:0] exp);
    chk(tag, {59'd0, mac_en, acc_clr, acc_wr, busy, done}, {59'd0, exp});
  endtask

  task automatic chk_idx(input string tag, input logic [15:0] ei,
                         input logic [15:0] ej, input logic [15:0] ek);
    chk(tag, {16'd0, idx_i, idx_j, idx_k}, {16'd0, ei, ej, ek});
  endtask

  // Runs a full nest, optionally stalling for slen cycles before beat sat.
  task automatic run_nest(input int m, input int n, input int k,
                          input int sat, input int slen);
    int b;
    dim_m = 16'(m);
    dim_n = 16'(n);
    dim_k = 16'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    b = 0;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        for (int kk = 0; kk < k; kk++) begin
          if (b == sat) begin
            stall = 1'b1;
            #1;
            repeat (slen) begin
              chk_flags("stall_flags", 5'b00010);
              chk_idx("stall_idx", 16'(i), 16'(j), 16'(kk));
              tick();
            end
            stall = 1'b0;
            #1;
          end
          chk_flags("beat_flags",
                    {1'b1, kk == 0, kk == k - 1, 1'b1, 1'b0});
          chk_idx("beat_idx", 16'(i), 16'(j), 16'(kk));
          tick();
          b++;
        end
    chk_flags("done_flags", 5'b00011);
    chk_idx("done_idx", 16'd0, 16'd0, 16'd0);
    tick();
    chk_flags("idle_flags", 5'b00000);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    dim_m = 16'd0;
    dim_n = 16'd0;
    dim_k = 16'd0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk_flags("reset_flags", 5'b00000);
    chk_idx("reset_idx", 16'd0, 16'd0, 16'd0);
    tick();
    reset = 1'b1;
    tick();
    chk_flags("post_reset_idle", 5'b00000);

    // Basic 2x2x2 nest; start held high with other dims must be ignored.
    dim_m = 16'd2; dim_n = 16'd2; dim_k = 16'd2;
    start = 1'b1;
    tick();
    dim_m = 16'd3; dim_n = 16'd3; dim_k = 16'd3;
    #1;
    for (int b = 0; b < 8; b++) begin
      if (b == 7) start = 1'b0;
      #1;
      chk_flags("basic_flags", {1'b1, b[0] == 1'b0, b[0] == 1'b1, 1'b1, 1'b0});
      chk_idx("basic_idx", 16'(b >> 2), 16'((b >> 1) & 1), 16'(b & 1));
      tick();
    end
    chk_flags("basic_done", 5'b00011);
    tick();
    chk_flags("basic_idle", 5'b00000);

    // Stall of 3 cycles at (0,1,0).
    run_nest(2, 2, 2, 2, 3);

    // Zero dimension goes straight to DONE.
    dim_m = 16'd3; dim_n = 16'd2; dim_k = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk_flags("zero_done", 5'b00011);
    tick();
    chk_flags("zero_idle", 5'b00000);
    tick();
    chk_flags("zero_idle2", 5'b00000);

    // Abort at beat 10 of a 4x4x4 nest, with stall also high.
    dim_m = 16'd4; dim_n = 16'd4; dim_k = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk_idx("abort_pre_idx", 16'd0, 16'd2, 16'd1);
    abort = 1'b1;
    stall = 1'b1;
    #1;
    chk_flags("abort_beat", 5'b00010);
    tick();
    abort = 1'b0;
    stall = 1'b0;
    #1;
    chk_flags("abort_idle", 5'b00000);
    chk_idx("abort_idx", 16'd0, 16'd0, 16'd0);
    tick();
    chk_flags("abort_no_done", 5'b00000);
    run_nest(1, 2, 3, -1, 0);

    // Single beat; abort high in IDLE must not block the start.
    abort = 1'b1;
    dim_m = 16'd1; dim_n = 16'd1; dim_k = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk_flags("single_beat", 5'b11110);
    chk_idx("single_idx", 16'd0, 16'd0, 16'd0);
    tick();
    chk_flags("single_done", 5'b00011);
    tick();
    chk_flags("single_idle", 5'b00000);

    // Reset dropped between edges mid-run.
    dim_m = 16'd2; dim_n = 16'd2; dim_k = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk_idx("rst_pre_idx", 16'd0, 16'd1, 16'd1);
    reset = 1'b0;
    #1;
    chk_flags("rst_mid_flags", 5'b00000);
    chk_idx("rst_mid_idx", 16'd0, 16'd0, 16'd0);
    tick();
    reset = 1'b1;
    tick();
    chk_flags("rst_release_idle", 5'b00000);
    run_nest(2, 1, 2, -1, 0);

    // Wide K exercises full-width last-index compare.
    run_nest(1, 1, 300, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
